// File: rtl/mips_control_muldiv_sequencer_if.sv
// EX-stage <-> HI/LO multiply/divide unit bus: issue, flush, HI/LO read requests,
// and the unit's interlock, busy flag and architectural HI/LO values.
interface mips_control_muldiv_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             flush;
  logic             readHi;
  logic             readLo;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operandA, operandB, flush, readHi, readLo,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  start, op, operandA, operandB, flush, readHi, readLo,
    output stall, busy, hi, lo
  );
endinterface

// File: rtl/mips_control_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, with sign fixup and ownership of architectural HI/LO.
module mips_control_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  mips_control_muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Working registers: acc_hi/acc_lo hold partial product or remainder/quotient,
  // opb holds the multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] raw_a;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_narrow(input logic [WIDTH-1:0] v,
                                                  input logic             en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide(input logic [2*WIDTH-1:0] v,
                                                  input logic               en);
    return en ? -v : v;
  endfunction

  logic             is_arith;
  logic             signed_op;
  logic             div_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    is_arith  = !bus.op[2];
    signed_op = !bus.op[2] && !bus.op[0];
    div_op    = bus.op[1];
    a_neg     = signed_op && bus.operandA[WIDTH-1];
    b_neg     = signed_op && bus.operandB[WIDTH-1];
    abs_a     = abs_val(bus.operandA, signed_op);
    abs_b     = abs_val(bus.operandB, signed_op);
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_nx;
  logic [WIDTH-1:0] div_lo_nx;

  // One iteration: add-and-shift-right for multiply; shift-left, trial subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    div_ok    = !div_trial[WIDTH];
    div_hi_nx = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_nx = {acc_lo[WIDTH-2:0], div_ok};
  end

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Divide by zero skips sign correction: quotient all ones, remainder = dividend as issued.
  always_comb begin
    fix_prod = neg_wide({acc_hi, acc_lo}, neg_q);
    fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
    fix_lo   = fix_prod[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = raw_a;
        fix_lo = '1;
      end else begin
        fix_hi = neg_narrow(acc_hi, neg_r);
        fix_lo = neg_narrow(acc_lo, neg_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (is_arith) begin
              state    <= BUSY;
              busy_q   <= 1'b1;
              count    <= '0;
              acc_hi   <= '0;
              acc_lo   <= div_op ? abs_a : abs_b;
              opb      <= div_op ? abs_b : abs_a;
              raw_a    <= bus.operandA;
              is_div   <= div_op;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= div_op && (bus.operandB == '0);
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.operandA;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.operandA;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc_hi <= is_div ? div_hi_nx : mul_hi_nx;
            acc_lo <= is_div ? div_lo_nx : mul_lo_nx;
            count  <= count + CNT_W'(1);
            if (count == LAST_ITER) state <= FIXUP;
          end
        end
        FIXUP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q && (bus.start || bus.readHi || bus.readLo);

endmodule

// File: tb/tb_mips_control_muldiv_sequencer.sv
// Directed bench for the HI/LO multiply/divide sequencer with a scoreboard of expected
// {hi,lo} results computed by a behavioural model.
module tb_mips_control_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mips_control_muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mips_control_muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q;
    int              r;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4:    return {a, m_lo};
      3'd5:    return {m_hi, a};
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.operandA = a;
    bus.operandB = b;
    if (push) sb_q.push_back(model(o, a, b));
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic retire(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, bus.hi, e[63:32]);
      check({tag, "_lo"}, bus.lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    n = 0;
    issue(o, a, b, 1'b1);
    wait_done(n);
    check({tag, "_busy_cycles"}, n, 33);
    retire(tag);
  endtask

  initial begin
    int n;
    int bad;
    bus.start = 0; bus.op = 3'd7; bus.operandA = '0; bus.operandB = '0;
    bus.flush = 0; bus.readHi = 0; bus.readLo = 0;
    repeat (2) @(negedge clock);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", bus.busy, 32'h0);
    check("rst_stall", bus.stall, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // MTHI / MTLO in IDLE
    bus.start = 1; bus.op = 3'd4; bus.operandA = 32'h1234;
    sb_q.push_back(model(3'd4, 32'h1234, 32'h0));
    #1 check("mthi_stall", bus.stall, 32'h0);
    @(negedge clock);
    bus.start = 0;
    check("mthi_busy", bus.busy, 32'h0);
    retire("mthi");
    issue(3'd5, 32'h0000_5678, 32'h0, 1'b1);
    retire("mtlo");

    // Ignored issues: start with flush, and no-op codes
    bus.start = 1; bus.flush = 1; bus.op = 3'd4; bus.operandA = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.flush = 0; bus.op = 3'd6;
    @(negedge clock);
    bus.start = 0;
    check("ignore_busy", bus.busy, 32'h0);
    check("ignore_hi", bus.hi, m_hi);
    check("ignore_lo", bus.lo, m_lo);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0);
    run_op("div_zero", 3'd2, 32'hFFFF_FFF9, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minneg", 3'd0, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
      if (i == 3) rb = -rb;
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 3)), ra, rb);
    end

    // readLo held from the 5th busy cycle through FIXUP
    issue(3'd0, 32'd5, 32'hFFFF_FFF7, 1'b1);
    repeat (4) @(negedge clock);
    bus.readLo = 1;
    #1;
    n = 4; bad = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.stall !== 1'b1) bad++;
      n++;
      @(negedge clock);
    end
    check("readlo_stall_busy", bad, 0);
    check("readlo_busy_cycles", n, 33);
    check("readlo_stall_idle", bus.stall, 32'h0);
    retire("readlo");
    bus.readLo = 0;

    // MTLO issued during BUSY is held off, then accepted in the first IDLE cycle
    issue(3'd3, 32'd1000, 32'd3, 1'b1);
    @(negedge clock);
    bus.start = 1; bus.op = 3'd5; bus.operandA = 32'hCAFE_BABE;
    #1;
    n = 1; bad = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.stall !== 1'b1) bad++;
      n++;
      @(negedge clock);
    end
    check("mtlo_wait_stall", bad, 0);
    check("mtlo_wait_cycles", n, 33);
    check("mtlo_wait_unstall", bus.stall, 32'h0);
    retire("divu_before_mtlo");
    sb_q.push_back(model(3'd5, 32'hCAFE_BABE, 32'h0));
    @(negedge clock);
    bus.start = 0;
    check("mtlo_late_busy", bus.busy, 32'h0);
    retire("mtlo_late");

    // Flush in the 10th BUSY cycle of a DIV
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clock);
    bus.flush = 1;
    @(negedge clock);
    bus.flush = 0;
    check("flush_busy", bus.busy, 32'h0);
    check("flush_hi", bus.hi, m_hi);
    check("flush_lo", bus.lo, m_lo);

    // Flush coinciding with the FIXUP cycle suppresses the write
    issue(3'd1, 32'd9, 32'd9, 1'b0);
    repeat (32) @(negedge clock);
    check("fixflush_busy_before", bus.busy, 32'h1);
    bus.flush = 1;
    @(negedge clock);
    bus.flush = 0;
    check("fixflush_busy", bus.busy, 32'h0);
    @(negedge clock);
    check("fixflush_hi", bus.hi, m_hi);
    check("fixflush_lo", bus.lo, m_lo);

    // Asynchronous reset mid-MULT
    issue(3'd0, 32'd123, 32'd456, 1'b0);
    repeat (6) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("areset_busy", bus.busy, 32'h0);
    check("areset_hi", bus.hi, 32'h0);
    check("areset_lo", bus.lo, 32'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op("after_reset", 3'd3, 32'd1000, 32'd7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
